// File: rtl/mapper_mem_responder.sv
// mapper_mem_responder: turns mapper RAM requests into single registered
// memory accesses and returns read data to the CPU, stretching the CPU cycle
// with cpu_wait until the memory acknowledges.
// Optional feature: define MAPPER_RESP_CACHE_EN to add a one-entry read cache
// that answers repeated reads of the same address without a memory access.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no access in flight; a request on ram_cs is accepted here
// BUSY  | memory access issued, waiting for mem_ack
// HOLD  | access served; waiting for ram_cs to drop so it is served only once
module mapper_mem_responder #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ram_cs,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_rnw,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_wait,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              cache_hit;
    logic [DATA_W-1:0] hit_data;
    logic              issue;
    logic              done;
    logic              hit_go;

`ifdef MAPPER_RESP_CACHE_EN
    logic              cache_vld;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_data;

    assign cache_hit = cache_vld && ram_rnw && (ram_addr == cache_addr);
    assign hit_data  = cache_data;

    // Cache entry: refilled by every completed read, kept coherent by writes
    // that complete to the cached address.
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_vld  <= 1'b0;
            cache_addr <= '1;
            cache_data <= '0;
        end else if (done) begin
            if (!mem_we) begin
                cache_vld  <= 1'b1;
                cache_addr <= mem_addr;
                cache_data <= mem_rdata;
            end else if (cache_vld && (mem_addr == cache_addr)) begin
                cache_data <= mem_wdata;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_data  = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, wait-state request and datapath strobes.
    always_comb begin
        state_nxt = state;
        cpu_wait  = 1'b0;
        issue     = 1'b0;
        done      = 1'b0;
        hit_go    = 1'b0;
        case (state)
            S_IDLE: begin
                if (ram_cs) begin
                    cpu_wait = 1'b1;
                    if (cache_hit) begin
                        hit_go    = 1'b1;
                        state_nxt = S_HOLD;
                    end else begin
                        issue     = 1'b1;
                        state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cpu_wait = 1'b1;
                if (mem_ack) begin
                    done      = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!ram_cs) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Memory request registers and CPU read data; the request fields are
    // captured once at issue so mapper changes during the access are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '1;
            mem_wdata <= '0;
            cpu_rdata <= '1;
        end else if (issue) begin
            mem_req   <= 1'b1;
            mem_addr  <= ram_addr;
            mem_we    <= ~ram_rnw;
            mem_wdata <= cpu_wdata;
        end else if (done) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
                cpu_rdata <= mem_rdata;
            end
        end else if (hit_go) begin
            cpu_rdata <= hit_data;
        end
    end

endmodule

// File: doc/mapper_mem_responder.md
MAPPER_MEM_RESPONDER -- requirements
Module: mapper_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, memory address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width in bits.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous to clk, active-high.
REQ-005 SHALL have port ram_cs  input  1  mapper request valid.
REQ-006 SHALL have port ram_addr  input  ADDR_W  mapper address; all-ones when not selected.
REQ-007 SHALL have port ram_rnw  input  1  1 = read, 0 = write.
REQ-008 SHALL have port cpu_wdata  input  DATA_W  CPU write data.
REQ-009 SHALL have port cpu_rdata  output  DATA_W  registered read data returned to the CPU.
REQ-010 SHALL have port cpu_wait  output  1  CPU wait-state request.
REQ-011 SHALL have port mem_req  output  1  memory request, registered.
REQ-012 SHALL have port mem_addr  output  ADDR_W  memory address, registered.
REQ-013 SHALL have port mem_we  output  1  memory write enable, registered.
REQ-014 SHALL have port mem_wdata  output  DATA_W  memory write data, registered.
REQ-015 SHALL have port mem_ack  input  1  one-cycle completion pulse from memory.
REQ-016 SHALL have port mem_rdata  input  DATA_W  read data, valid in the mem_ack cycle.

Function
REQ-017 SHALL implement the states IDLE, BUSY and HOLD.
REQ-018 In IDLE with ram_cs=1, SHALL capture ram_addr, ~ram_rnw and cpu_wdata into mem_addr, mem_we and mem_wdata, set mem_req=1 and enter BUSY on the next edge.
REQ-019 In BUSY, SHALL hold mem_req, mem_addr, mem_we and mem_wdata stable until mem_ack=1 is sampled.
REQ-020 On mem_ack in BUSY, SHALL drop mem_req on the same edge, latch mem_rdata into cpu_rdata (reads only; writes leave cpu_rdata unchanged) and enter HOLD.
REQ-021 In HOLD, SHALL remain until ram_cs=0 and then return to IDLE, so that a held request is served exactly once.
REQ-022 cpu_wait SHALL be combinational and equal (IDLE & ram_cs) | BUSY, so wait asserts in the cycle the request appears and deasserts in the first HOLD cycle.
REQ-023 Minimum latency SHALL be: request cycle N, mem_req high at N+1, ack at N+1 gives HOLD and cpu_wait=0 at N+2.
REQ-024 mem_ack sampled in IDLE or HOLD SHALL be ignored, with no state or data change.
REQ-025 If ram_cs drops while in BUSY, the access SHALL still complete, after which the block goes to HOLD and then to IDLE on the next edge.
REQ-026 ram_addr and ram_rnw changes while BUSY or HOLD SHALL be ignored.

Reset
REQ-027 On reset=1, SHALL enter IDLE and clear mem_req=0, mem_we=0, mem_addr=all-ones, mem_wdata=0 and cpu_rdata=all-ones.
REQ-028 A reset asserted mid-access SHALL abandon the access: mem_req=0 on the next edge, and a late mem_ack is ignored.

Configuration
REQ-029 With MAPPER_RESP_CACHE_EN defined, SHALL keep a one-entry read cache holding the address, data and a valid bit (valid cleared by reset).
REQ-030 With the cache, a read in IDLE whose address equals the valid cached address SHALL go directly to HOLD with cpu_rdata=cached data, mem_req never asserted and cpu_wait high for that one cycle only.
REQ-031 With the cache, each completed read SHALL refill the entry, and any write to the cached address SHALL update the cached data.
REQ-032 Without MAPPER_RESP_CACHE_EN, every request SHALL issue a memory access, and no cache storage SHALL be synthesized.

Verification
REQ-033 Read 0x0004123, mem_rdata=0xA5, ack 3 cycles after mem_req -> mem_req high 3 cycles, cpu_rdata=0xA5, cpu_wait high 4 cycles.
REQ-034 Write 0x3C to 0x0000010 -> mem_we=1, mem_wdata=0x3C, mem_addr=0x0000010; cpu_rdata unchanged after ack.
REQ-035 ram_cs held 10 cycles after ack -> exactly one mem_req pulse, and stray mem_ack pulses in HOLD have no effect.
REQ-036 Reset asserted during BUSY, then ack one cycle later -> mem_req=0, state IDLE, cpu_rdata=0xFF.
REQ-037 Cache enabled, two reads of 0x0000200 with ram_cs low between them -> one memory access; second read returns the same data with 1 wait cycle.
REQ-038 Cache enabled, read 0x200 (0x11), write 0x22 to 0x200, read 0x200 -> 0x22 returned, no memory access for the final read.
